regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU, the load-response path, decode and the register file.
// The master modport is the environment side; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    localparam int NREG = 2 ** ADDRESS_WIDTH;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     mem_valid;
    logic                     mem_ready;
    logic [ADDRESS_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]    mem_data;

    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_rd;
    logic [NREG-1:0]          busy;

    logic                     rf_we;
    logic [ADDRESS_WIDTH-1:0] rf_ad;
    logic [DATA_WIDTH-1:0]    rf_wd;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd,
        input  alu_ready, mem_ready, busy, rf_we, rf_ad, rf_wd
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd,
        output alu_ready, mem_ready, busy, rf_we, rf_ad, rf_wd
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-port register-file writeback arbiter: ALU results win, buffered load beats
// are drained from a small FIFO, with a starvation guard and a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int NREG  = 2 ** ADDRESS_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } beat_t;

    beat_t                    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]               starv_q, starv_d;
    logic [NREG-1:0]          busy_q, busy_d;
    logic                     rf_we_q, rf_we_d;
    logic [ADDRESS_WIDTH-1:0] rf_ad_q, rf_ad_d;
    logic [DATA_WIDTH-1:0]    rf_wd_q, rf_wd_d;

    logic  fifo_empty, fifo_full, force_pop, alu_win, push, pop;
    beat_t head;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (all bits equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    assign force_pop  = (starv_q == 2'd3) && !fifo_empty;
    assign alu_win    = bus.alu_valid && !force_pop;
    assign push       = bus.mem_valid && !fifo_full;
    assign pop        = !alu_win && !fifo_empty;

    assign bus.alu_ready = rst || !force_pop;
    assign bus.mem_ready = rst || !fifo_full;
    assign bus.busy      = busy_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_ad     = rf_ad_q;
    assign bus.rf_wd     = rf_wd_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
        starv_d  = starv_q;
        rf_we_d  = 1'b0;
        rf_ad_d  = rf_ad_q;
        rf_wd_d  = rf_wd_q;

        // Writes to r0 still use their slot but never reach the register file.
        if (alu_win) begin
            rf_we_d = (bus.alu_rd != '0);
            rf_ad_d = bus.alu_rd;
            rf_wd_d = bus.alu_data;
        end else if (pop) begin
            rf_we_d = (head.rd != '0);
            rf_ad_d = head.rd;
            rf_wd_d = head.data;
        end

        if (pop || fifo_empty) begin
            starv_d = 2'd0;
        end else if (alu_win) begin
            starv_d = starv_q + 2'd1;
        end

        // Set after clear so a same-cycle reservation of the register being written wins.
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (rf_we_q && rf_ad_q == ADDRESS_WIDTH'(r)) busy_d[r] = 1'b0;
            if (bus.issue_valid && bus.issue_rd == ADDRESS_WIDTH'(r)) busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starv_q  <= '0;
            busy_q   <= '0;
            rf_we_q  <= 1'b0;
            rf_ad_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starv_q  <= starv_d;
            busy_q   <= busy_d;
            rf_we_q  <= rf_we_d;
            rf_ad_q  <= rf_ad_d;
            rf_wd_q  <= rf_wd_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define
    // which entries are valid, so this can map onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{rd: bus.mem_rd, data: bus.mem_data};
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: latency, arbitration,
// starvation guard, scoreboard and reset behaviour with hand-computed expectations.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = data;
    endtask

    task automatic drive_issue(input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
    endtask

    // issue r3 in cycle 0, ALU write r3 in cycle 4, optional re-issue of r3 in cycle 5
    task automatic run_busy(input bit reissue);
        idle();
        drive_issue(5'd3);
        step();
        for (int c = 1; c <= 7; c++) begin
            idle();
            if (c == 4) drive_alu(5'd3, 32'h0000_0033);
            if (c == 5 && reissue) drive_issue(5'd3);
            check($sformatf("busy3_r%0d_c%0d", reissue, c), bus.busy[3], (c <= 5) || reissue);
            if (c == 5) begin
                check($sformatf("busy_wr_we_r%0d", reissue), bus.rf_we, 1'b1);
                check($sformatf("busy_wr_ad_r%0d", reissue), bus.rf_ad, 5'd3);
            end
            step();
        end
        if (reissue) begin
            idle();
            drive_alu(5'd3, 32'h0000_0034);
            step();
            idle();
            step();
            check("busy3_cleanup", bus.busy[3], 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit         alu_rdy_exp [9];
        bit         mem_rdy_exp [6];
        int         beat;
        int         alu_cnt;
        logic [4:0] wr_ad [$];
        logic [31:0] wr_wd [$];

        // ---------------- reset: inputs active but ignored ----------------
        rst = 1'b1;
        idle();
        step();
        drive_alu(5'd4, 32'h1);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd4;
        bus.mem_data  = 32'h2;
        drive_issue(5'd4);
        step();
        step();
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_rf_ad", bus.rf_ad, 5'd0);
        check("rst_rf_wd", bus.rf_wd, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_alu_ready", bus.alu_ready, 1'b1);
        check("rst_mem_ready", bus.mem_ready, 1'b1);
        idle();
        rst = 1'b0;
        step();
        check("post_rst_we", bus.rf_we, 1'b0);
        step();

        // ---------------- ALU latency 1 ----------------
        drive_alu(5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        check("alu_we", bus.rf_we, 1'b1);
        check("alu_ad", bus.rf_ad, 5'd5);
        check("alu_wd", bus.rf_wd, 32'hDEAD_BEEF);
        step();
        check("alu_we_off", bus.rf_we, 1'b0);

        // ---------------- load latency 2 ----------------
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h1234_5678;
        step();
        idle();
        check("load_c1_we", bus.rf_we, 1'b0);
        step();
        check("load_c2_we", bus.rf_we, 1'b1);
        check("load_c2_ad", bus.rf_ad, 5'd7);
        check("load_c2_wd", bus.rf_wd, 32'h1234_5678);
        step();
        check("load_c3_we", bus.rf_we, 1'b0);

        // ---------------- scoreboard ----------------
        run_busy(1'b0);
        run_busy(1'b1);

        // ---------------- r0 writes and reservations ----------------
        idle();
        drive_alu(5'd0, 32'hFFFF_FFFF);
        drive_issue(5'd0);
        step();
        idle();
        check("r0_we", bus.rf_we, 1'b0);
        check("r0_busy", bus.busy, 32'd0);
        step();
        check("r0_busy_later", bus.busy, 32'd0);

        // ---------------- starvation guard, full FIFO, ordering ----------------
        alu_rdy_exp = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
        mem_rdy_exp = '{1, 1, 1, 1, 0, 1};
        beat    = 0;
        alu_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            idle();
            if (c < 9) drive_alu(5'd1, 32'(alu_cnt));
            if (beat < 5) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = 5'(10 + beat);
                bus.mem_data  = 32'hA0 + 32'(beat);
            end
            #1;
            if (c < 9) check($sformatf("starv_alu_ready_c%0d", c), bus.alu_ready, alu_rdy_exp[c]);
            if (c < 6) check($sformatf("starv_mem_ready_c%0d", c), bus.mem_ready, mem_rdy_exp[c]);
            if (bus.alu_valid && bus.alu_ready) alu_cnt++;
            if (bus.mem_valid && bus.mem_ready) beat++;
            if (bus.rf_we && bus.rf_ad >= 5'd10) begin
                wr_ad.push_back(bus.rf_ad);
                wr_wd.push_back(bus.rf_wd);
            end
            step();
        end
        idle();
        check("starv_beats_accepted", 64'(beat), 64'd5);
        check("starv_alu_accepted", 64'(alu_cnt), 64'd7);
        check("starv_load_writes", 64'(wr_ad.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_ad.size()) begin
                check($sformatf("order_ad_%0d", i), wr_ad[i], 5'(10 + i));
                check($sformatf("order_wd_%0d", i), wr_wd[i], 32'hA0 + 32'(i));
            end
        end
        step();

        // ---------------- reset discards buffered loads and scoreboard ----------------
        for (int c = 0; c < 3; c++) begin
            idle();
            drive_alu(5'd1, 32'h55);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'(20 + c);
            bus.mem_data  = 32'hC0 + 32'(c);
            if (c == 0) drive_issue(5'd9);
            step();
        end
        idle();
        check("pre_rst_busy9", bus.busy[9], 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_alu_ready", bus.alu_ready, 1'b1);
        check("midrst_mem_ready", bus.mem_ready, 1'b1);
        step();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 32'd0);
        check("midrst_we", bus.rf_we, 1'b0);
        check("midrst_mem_ready_after", bus.mem_ready, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("postrst_no_write_c%0d", c), bus.rf_we, 1'b0);
        end
        check("postrst_mem_ready", bus.mem_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
